// File: rtl/vga_capture.sv
// vga_capture: registers a VGA pixel stream, frames it and delivers it on an Avalon-ST source through a show-ahead FIFO.
// Define VGA_CAPTURE_STATS_EN to build the frame_count / line_width statistics; otherwise both outputs read 0.
module vga_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_HS,
  input  logic        vga_VS,
  input  logic        vga_BLANK,
  input  logic [7:0]  vga_R,
  input  logic [7:0]  vga_G,
  input  logic [7:0]  vga_B,
  output logic [23:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_sop,
  output logic        src_eop,
  input  logic        clr_ovf,
  output logic        overflow,
  output logic [15:0] frame_count,
  output logic [11:0] line_width
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);

  typedef enum logic [1:0] {WAIT_VS, WAIT_ACTIVE, CAPTURE, DROP} state_t;

  state_t        state;
  logic          hs_q, vs_q, vs_d, blank_q;
  logic [23:0]   rgb_q;
  logic [11:0]   x, y;
  logic          line_done;
  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [25:0]   head;
  logic          vs_fall, full, pop, can_push, attempt, push, ovf_event;
  logic          push_sop, push_eop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      vs_d    <= 1'b0;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hs_q    <= vga_HS;
      vs_q    <= vga_VS;
      vs_d    <= vs_q;
      blank_q <= vga_BLANK;
      rgb_q   <= {vga_R, vga_G, vga_B};
    end
  end

  assign vs_fall   = vs_d && !vs_q;
  assign full      = (count == FULL_CNT);
  assign src_valid = (count != '0);
  assign pop       = src_valid && src_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign can_push  = !full || pop;
  assign attempt   = !vs_fall && blank_q &&
                     ((state == WAIT_ACTIVE) || ((state == CAPTURE) && !line_done));
  assign push      = attempt && can_push;
  assign ovf_event = attempt && !can_push;
  assign push_sop  = (x == '0) && (y == '0);
  assign push_eop  = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_VS;
      x         <= '0;
      y         <= '0;
      line_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ovf_event) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (!blank_q || !hs_q) line_done <= 1'b0;
      if (vs_fall) begin
        state     <= WAIT_ACTIVE;
        x         <= '0;
        y         <= '0;
        line_done <= 1'b0;
      end else if (ovf_event) begin
        state <= DROP;
      end else if (push) begin
        state <= push_eop ? WAIT_VS : CAPTURE;
        if (x == X_LAST) begin
          x         <= '0;
          y         <= y + 12'd1;
          line_done <= 1'b1;
        end else begin
          x <= x + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rgb_q, push_sop, push_eop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign src_data = src_valid ? head[25:2] : 24'd0;
  assign src_sop  = src_valid && head[1];
  assign src_eop  = src_valid && head[0];

`ifdef VGA_CAPTURE_STATS_EN
  logic        blank_d;
  logic [15:0] frame_cnt;
  logic [11:0] pix_cnt, width_q;

  // The width is latched when BLANK falls, then the counter restarts for the next line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_d   <= 1'b0;
      frame_cnt <= '0;
      pix_cnt   <= '0;
      width_q   <= '0;
    end else begin
      blank_d <= blank_q;
      if (push && push_eop) frame_cnt <= frame_cnt + 16'd1;
      if (blank_d && !blank_q) begin
        width_q <= pix_cnt;
        pix_cnt <= '0;
      end else if (blank_q && (pix_cnt != 12'hFFF)) begin
        pix_cnt <= pix_cnt + 12'd1;
      end
    end
  end

  assign frame_count = frame_cnt;
  assign line_width  = width_q;
`else
  assign frame_count = 16'd0;
  assign line_width  = 12'd0;
`endif

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two ≥ 4: pixel buffer entries.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, reset_n.
REQ-005 clk  input  1  pixel clock; VGA inputs are synchronous to it.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 vga_HS  input  1  horizontal sync, active-low.
REQ-008 vga_VS  input  1  vertical sync, active-low.
REQ-009 vga_BLANK  input  1  active-low blank: 1 = active pixel, 0 = blanking.
REQ-010 vga_R, vga_G, vga_B  input  8 each  pixel colour.
REQ-011 src_data  output  24  pixel {R,G,B}, Avalon-ST source.
REQ-012 src_valid  output  1  src_data valid.
REQ-013 src_ready  input  1  sink accepts the beat.
REQ-014 src_sop, src_eop  output  1 each  first and last pixel of the frame.
REQ-015 clr_ovf  input  1  one-cycle pulse that clears overflow.
REQ-016 overflow  output  1  sticky flag: a pixel was dropped because the FIFO was full.
REQ-017 frame_count  output  16  completed frames (statistics).
REQ-018 line_width  output  12  measured active pixels in the last line (statistics).

Function
REQ-019 All VGA inputs are registered once before use; edges are detected on the registered values.
REQ-020 FSM states: WAIT_VS, WAIT_ACTIVE, CAPTURE, DROP.
REQ-021 Falling edge of VS in any state: go to WAIT_ACTIVE, clear x and y to 0. A partially captured frame is abandoned without src_eop.
REQ-022 WAIT_ACTIVE: on the first active pixel, go to CAPTURE and push that pixel.
REQ-023 CAPTURE: every active pixel is pushed; x increments.
- At x == H_ACTIVE-1: x wraps to 0 and y increments.
- Active pixels past H_ACTIVE on a line are discarded.
REQ-024 Each push carries flags: sop = (x==0 && y==0); eop = (x==H_ACTIVE-1 && y==V_ACTIVE-1).
REQ-025 After the eop push: go to WAIT_VS and increment frame_count (wraps at 2^16). Further active pixels are ignored.
REQ-026 Push attempted while the FIFO is full: discard the pixel, set overflow, go to DROP. DROP leaves only on a VS falling edge (REQ-021).
REQ-027 The FIFO is show-ahead, so src_valid=1 whenever it is non-empty. A pop occurs only when src_valid && src_ready.
REQ-028 While src_valid=1 && src_ready=0, src_data, src_sop and src_eop are held stable.
REQ-029 Latency: a pixel present on the VGA inputs in cycle N appears on src_data in cycle N+2 when the FIFO is empty.
REQ-030 Simultaneous push and pop with the FIFO full: the pop frees the entry and the push succeeds; no overflow.
REQ-031 clr_ovf in the same cycle as a new overflow event: set wins.
REQ-032 line_width: counts active pixels between BLANK rising and falling edges. It updates on the BLANK falling edge and saturates at 4095.

Reset
REQ-033 reset_n low, asynchronously:
- state = WAIT_VS; FIFO empty;
- src_valid = 0; src_data = 0; src_sop = 0; src_eop = 0;
- overflow = 0; frame_count = 0; line_width = 0;
- x, y and input registers = 0.
REQ-034 Deasserting reset mid-frame: no capture until the next VS falling edge.

Configuration
REQ-035 Macro VGA_CAPTURE_STATS_EN selects the statistics logic.
- Defined: frame_count and line_width are implemented per REQ-025 and REQ-032.
- Undefined: both are tied to 0 and their counters are not synthesized; all other behaviour is unchanged.

Verification
All scenarios use H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4, src_ready=1 unless stated.
REQ-036 One frame of 8 active pixels with values 1..8 -> 8 beats, data 1..8, sop on beat 1, eop on beat 8, frame_count=1, overflow=0.
REQ-037 src_ready=0 throughout a frame -> 4 pixels buffered and overflow=1. Then raise src_ready and run the next frame -> beats 1..4 drain, then the new frame starts with sop and has no loss.
REQ-038 VS falling edge after 3 pixels -> no eop for that frame. The next full frame is delivered with sop and eop correct; frame_count increments only for the full frame.
REQ-039 6 active pixels on a line -> only 4 pushed for that line; line_width=6 (stats enabled), 0 (stats disabled).
REQ-040 reset_n pulsed low during CAPTURE -> outputs at reset values within the same cycle. Pixels are ignored until the next VS falling edge.
REQ-041 clr_ovf coincident with an overflowing push -> overflow stays 1. clr_ovf alone on the next cycle -> overflow=0.
